// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch core.
//   state_e    : control state (IDLE, RUN, PAUSE, LAP)
//   time_t     : six packed BCD nibbles, MM:SS.hh, most significant first
//   BCD_MAX_*  : digit wrap limits
//   calc_div   : prescaler division ratio
//   div_width  : prescaler counter width
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX_9 = 4'd9;
    localparam logic [3:0] BCD_MAX_5 = 4'd5;

    typedef struct packed {
        logic [3:0] min_hi;
        logic [3:0] min_lo;
        logic [3:0] s_hi;
        logic [3:0] s_lo;
        logic [3:0] ms_hi;
        logic [3:0] ms_lo;
    } time_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // A counter over 0..div-1 needs at least one bit.
    function automatic int div_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control pulses and display outputs of the stopwatch core.
//   master : key front-end / consumer side (drives pulses, reads digits)
//   slave  : stopwatch core side
interface stopwatch_ctrl_if;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] min_higher;
    logic [3:0] min_lower;
    logic [3:0] s_higher;
    logic [3:0] s_lower;
    logic [3:0] ms_higher;
    logic [3:0] ms_lower;
    logic       running;
    logic       frozen;
    logic       wrap;

    modport master (
        output start_stop, clear, lap,
        input  min_higher, min_lower, s_higher, s_lower, ms_higher, ms_lower,
        input  running, frozen, wrap
    );

    modport slave (
        input  start_stop, clear, lap,
        output min_higher, min_lower, s_higher, s_lower, ms_higher, ms_lower,
        output running, frozen, wrap
    );
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// Single BCD digit counter with wrap at MAX and combinational carry.
//   clock, reset : system clock, synchronous active-high reset
//   clr_i        : synchronous zero
//   inc_i        : increment request
//   value_o      : current digit
//   carry_o      : high when this increment wraps the digit
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] value_o,
    output logic       carry_o
);

    logic [3:0] value_q;

    // Digit register; any out-of-range value folds back to zero on the next increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= 4'd0;
        end else if (clr_i) begin
            value_q <= 4'd0;
        end else if (inc_i) begin
            value_q <= (value_q >= MAX) ? 4'd0 : value_q + 4'd1;
        end
    end

    assign value_o = value_q;
    assign carry_o = inc_i && (value_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: prescaler, MM:SS.hh BCD chain, run/pause/clear/lap control.
//   clock, reset : system clock, synchronous active-high reset
//   sw (slave)   : start_stop/clear/lap pulses in; six BCD digits,
//                  running, frozen and wrap out (all registered)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 100,
    parameter int MIN_HI_MAX = 5
) (
    input  logic            clock,
    input  logic            reset,
    stopwatch_ctrl_if.slave sw
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = div_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [3:0]    MIN_HI_LIM = 4'(MIN_HI_MAX);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    time_t         lap_q;
    time_t         disp_q, disp_d;
    time_t         live_s;
    logic          running_q, frozen_q, wrap_q;
    logic          lap_load_s;
    logic          time_clr_s;
    logic          advance_s;
    logic          tick_s;
    logic [5:0]    carry_s;

    // Next state; clear beats start_stop beats lap, each only where it applies.
    always_comb begin
        state_d    = state_q;
        lap_load_s = 1'b0;
        time_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (sw.start_stop) state_d = RUN;
                else               state_d = IDLE;
            end
            RUN: begin
                if (sw.start_stop) begin
                    state_d = PAUSE;
                end else if (sw.lap) begin
                    state_d    = LAP;
                    lap_load_s = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            LAP: begin
                if (sw.start_stop) state_d = PAUSE;
                else if (sw.lap)   state_d = RUN;
                else               state_d = LAP;
            end
            PAUSE: begin
                if (sw.clear) begin
                    state_d    = IDLE;
                    time_clr_s = 1'b1;
                end else if (sw.start_stop) begin
                    state_d = RUN;
                end else begin
                    state_d = PAUSE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign advance_s = (state_q == RUN) || (state_q == LAP);

    // Prescaler: held while paused so the partial tick survives a pause.
    always_comb begin
        presc_d = presc_q;
        tick_s  = 1'b0;
        if (time_clr_s) begin
            presc_d = '0;
        end else if (advance_s) begin
            if (presc_q == PRESC_LAST) begin
                tick_s  = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    bcd_digit #(.MAX(BCD_MAX_9)) u_ms_lo (
        .clock(clock), .reset(reset), .clr_i(time_clr_s), .inc_i(tick_s),
        .value_o(live_s.ms_lo), .carry_o(carry_s[0])
    );
    bcd_digit #(.MAX(BCD_MAX_9)) u_ms_hi (
        .clock(clock), .reset(reset), .clr_i(time_clr_s), .inc_i(carry_s[0]),
        .value_o(live_s.ms_hi), .carry_o(carry_s[1])
    );
    bcd_digit #(.MAX(BCD_MAX_9)) u_s_lo (
        .clock(clock), .reset(reset), .clr_i(time_clr_s), .inc_i(carry_s[1]),
        .value_o(live_s.s_lo), .carry_o(carry_s[2])
    );
    bcd_digit #(.MAX(BCD_MAX_5)) u_s_hi (
        .clock(clock), .reset(reset), .clr_i(time_clr_s), .inc_i(carry_s[2]),
        .value_o(live_s.s_hi), .carry_o(carry_s[3])
    );
    bcd_digit #(.MAX(BCD_MAX_9)) u_min_lo (
        .clock(clock), .reset(reset), .clr_i(time_clr_s), .inc_i(carry_s[3]),
        .value_o(live_s.min_lo), .carry_o(carry_s[4])
    );
    bcd_digit #(.MAX(MIN_HI_LIM)) u_min_hi (
        .clock(clock), .reset(reset), .clr_i(time_clr_s), .inc_i(carry_s[4]),
        .value_o(live_s.min_hi), .carry_o(carry_s[5])
    );

    // Display source: frozen lap snapshot while in LAP, live time otherwise.
    always_comb begin
        disp_d = live_s;
        if (state_q == LAP) disp_d = lap_q;
        else                disp_d = live_s;
    end

    // State, prescaler, lap snapshot and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            lap_q     <= '0;
            disp_q    <= '0;
            running_q <= 1'b0;
            frozen_q  <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            // Snapshot takes the pre-increment time if a tick lands on the same edge.
            if (lap_load_s) lap_q <= live_s;
            disp_q    <= disp_d;
            running_q <= (state_d == RUN) || (state_d == LAP);
            frozen_q  <= (state_d == LAP);
            wrap_q    <= carry_s[5];
        end
    end

    assign sw.min_higher = disp_q.min_hi;
    assign sw.min_lower  = disp_q.min_lo;
    assign sw.s_higher   = disp_q.s_hi;
    assign sw.s_lower    = disp_q.s_lo;
    assign sw.ms_higher  = disp_q.ms_hi;
    assign sw.ms_lower   = disp_q.ms_lo;
    assign sw.running    = running_q;
    assign sw.frozen     = frozen_q;
    assign sw.wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV = 10. A second instance with
// MIN_HI_MAX = 0 covers roll-over; its digits are preset to 09:59.99 while
// paused because counting there from zero takes 600k cycles.
module tb_stopwatch_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    stopwatch_ctrl_if sw_if ();
    stopwatch_ctrl_if sww_if ();

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_HI_MAX(5)) dut (
        .clock(clk), .reset(rst), .sw(sw_if)
    );

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_HI_MAX(0)) dut_w (
        .clock(clk), .reset(rst), .sw(sww_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] disp();
        return {sw_if.min_higher, sw_if.min_lower, sw_if.s_higher,
                sw_if.s_lower, sw_if.ms_higher, sw_if.ms_lower};
    endfunction

    function automatic logic [23:0] disp_w();
        return {sww_if.min_higher, sww_if.min_lower, sww_if.s_higher,
                sww_if.s_lower, sww_if.ms_higher, sww_if.ms_lower};
    endfunction

    // Called just after a negedge: drive for one rising edge, return at the next negedge.
    task automatic pulse(input logic ss, input logic cl, input logic lp);
        sw_if.start_stop = ss;
        sw_if.clear      = cl;
        sw_if.lap        = lp;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
    endtask

    task automatic pulse_w(input logic ss);
        sww_if.start_stop = ss;
        @(negedge clk);
        sww_if.start_stop = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (disp() !== 24'h000000) begin errors++; $display("FAIL reset_digits: got %h expected %h", disp(), 24'h000000); end
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", sw_if.running); end
        checks++; if (sw_if.frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen: got %b expected 0", sw_if.frozen); end
        checks++; if (sw_if.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", sw_if.wrap); end
    endtask

    task automatic test_start();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);                 // edge 0
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", sw_if.running); end
        cycles(10);                              // edge 10: live becomes 1
        checks++; if (disp() !== 24'h000000) begin errors++; $display("FAIL start_before_inc: got %h expected %h", disp(), 24'h000000); end
        cycles(1);                               // edge 11: display follows
        checks++; if (disp() !== 24'h000001) begin errors++; $display("FAIL start_first_inc: got %h expected %h", disp(), 24'h000001); end
        cycles(989);                             // edge 1000
        checks++; if (disp() !== 24'h000099) begin errors++; $display("FAIL start_0099: got %h expected %h", disp(), 24'h000099); end
        cycles(1);                               // edge 1001
        checks++; if (disp() !== 24'h000100) begin errors++; $display("FAIL start_0100: got %h expected %h", disp(), 24'h000100); end
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL start_still_running: got %b expected 1", sw_if.running); end
    endtask

    task automatic test_pause();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);                 // edge 0
        cycles(24);
        pulse(1'b1, 1'b0, 1'b0);                 // edge 25: pause, prescaler at 5
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b expected 0", sw_if.running); end
        cycles(100);
        checks++; if (disp() !== 24'h000002) begin errors++; $display("FAIL pause_hold: got %h expected %h", disp(), 24'h000002); end
        pulse(1'b1, 1'b0, 1'b0);                 // resume edge R
        cycles(5);                               // R+5: live increments
        checks++; if (disp() !== 24'h000002) begin errors++; $display("FAIL resume_before_inc: got %h expected %h", disp(), 24'h000002); end
        cycles(1);                               // R+6
        checks++; if (disp() !== 24'h000003) begin errors++; $display("FAIL resume_inc: got %h expected %h", disp(), 24'h000003); end
    endtask

    task automatic test_clear();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);                 // edge 0
        cycles(34);
        pulse(1'b0, 1'b1, 1'b0);                 // edge 35: clear while running
        cycles(1);
        checks++; if (disp() !== 24'h000003) begin errors++; $display("FAIL clear_in_run: got %h expected %h", disp(), 24'h000003); end
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL clear_in_run_running: got %b expected 1", sw_if.running); end
        cycles(38);
        pulse(1'b1, 1'b0, 1'b0);                 // edge 75: pause at 00:00.07
        cycles(1);
        checks++; if (disp() !== 24'h000007) begin errors++; $display("FAIL clear_paused_at: got %h expected %h", disp(), 24'h000007); end
        pulse(1'b0, 1'b1, 1'b0);                 // clear -> IDLE
        cycles(1);
        checks++; if (disp() !== 24'h000000) begin errors++; $display("FAIL clear_zero: got %h expected %h", disp(), 24'h000000); end
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL clear_running: got %b expected 0", sw_if.running); end
        pulse(1'b1, 1'b0, 1'b0);                 // restart edge S, prescaler from 0
        cycles(10);
        checks++; if (disp() !== 24'h000000) begin errors++; $display("FAIL clear_presc_zero: got %h expected %h", disp(), 24'h000000); end
        cycles(1);
        checks++; if (disp() !== 24'h000001) begin errors++; $display("FAIL clear_restart_inc: got %h expected %h", disp(), 24'h000001); end
    endtask

    task automatic test_lap();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);                 // edge 0
        cycles(30);
        pulse(1'b0, 1'b0, 1'b1);                 // edge 31: lap at 00:00.03
        checks++; if (sw_if.frozen !== 1'b1) begin errors++; $display("FAIL lap_frozen: got %b expected 1", sw_if.frozen); end
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL lap_running: got %b expected 1", sw_if.running); end
        cycles(1);
        checks++; if (disp() !== 24'h000003) begin errors++; $display("FAIL lap_show: got %h expected %h", disp(), 24'h000003); end
        cycles(49);                              // edge 81: live is 8
        checks++; if (disp() !== 24'h000003) begin errors++; $display("FAIL lap_hold: got %h expected %h", disp(), 24'h000003); end
        pulse(1'b0, 1'b0, 1'b1);                 // edge 82: unfreeze
        checks++; if (sw_if.frozen !== 1'b0) begin errors++; $display("FAIL lap_unfrozen: got %b expected 0", sw_if.frozen); end
        cycles(1);
        checks++; if (disp() !== 24'h000008) begin errors++; $display("FAIL lap_live: got %h expected %h", disp(), 24'h000008); end
        cycles(6);
        pulse(1'b0, 1'b0, 1'b1);                 // edge 90: lap on a tick edge
        cycles(1);
        checks++; if (disp() !== 24'h000008) begin errors++; $display("FAIL lap_pre_inc: got %h expected %h", disp(), 24'h000008); end
        pulse(1'b1, 1'b0, 1'b0);                 // LAP -> PAUSE
        checks++; if ({sw_if.running, sw_if.frozen} !== 2'b00) begin errors++; $display("FAIL lap_to_pause: got %b expected 00", {sw_if.running, sw_if.frozen}); end
        cycles(1);
        checks++; if (disp() !== 24'h000009) begin errors++; $display("FAIL lap_pause_live: got %h expected %h", disp(), 24'h000009); end
    endtask

    task automatic test_idle_ignores();
        do_reset();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if ({sw_if.running, sw_if.frozen} !== 2'b00) begin errors++; $display("FAIL idle_ignore_flags: got %b expected 00", {sw_if.running, sw_if.frozen}); end
        cycles(20);
        checks++; if (disp() !== 24'h000000) begin errors++; $display("FAIL idle_ignore_digits: got %h expected %h", disp(), 24'h000000); end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse_w(1'b1);                           // edge 0: RUN
        pulse_w(1'b1);                           // edge 1: PAUSE, prescaler at 1
        force dut_w.u_ms_lo.value_q  = 4'd9;
        force dut_w.u_ms_hi.value_q  = 4'd9;
        force dut_w.u_s_lo.value_q   = 4'd9;
        force dut_w.u_s_hi.value_q   = 4'd5;
        force dut_w.u_min_lo.value_q = 4'd9;
        force dut_w.u_min_hi.value_q = 4'd0;
        cycles(1);
        release dut_w.u_ms_lo.value_q;
        release dut_w.u_ms_hi.value_q;
        release dut_w.u_s_lo.value_q;
        release dut_w.u_s_hi.value_q;
        release dut_w.u_min_lo.value_q;
        release dut_w.u_min_hi.value_q;
        pulse_w(1'b1);                           // resume edge R
        checks++; if (disp_w() !== 24'h095999) begin errors++; $display("FAIL wrap_preset: got %h expected %h", disp_w(), 24'h095999); end
        cycles(8);                               // R+8
        checks++; if (sww_if.wrap !== 1'b0) begin errors++; $display("FAIL wrap_early: got %b expected 0", sww_if.wrap); end
        cycles(1);                               // R+9: roll-over edge
        checks++; if (sww_if.wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got %b expected 1", sww_if.wrap); end
        checks++; if (disp_w() !== 24'h095999) begin errors++; $display("FAIL wrap_disp_lag: got %h expected %h", disp_w(), 24'h095999); end
        cycles(1);                               // R+10
        checks++; if (sww_if.wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle: got %b expected 0", sww_if.wrap); end
        checks++; if (disp_w() !== 24'h000000) begin errors++; $display("FAIL wrap_zero: got %h expected %h", disp_w(), 24'h000000); end
        cycles(10);                              // R+20
        checks++; if (disp_w() !== 24'h000001) begin errors++; $display("FAIL wrap_continue: got %h expected %h", disp_w(), 24'h000001); end
        checks++; if (sww_if.running !== 1'b1) begin errors++; $display("FAIL wrap_running: got %b expected 1", sww_if.running); end
    endtask

    task automatic test_clear_start_same();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);                 // edge 0
        cycles(4);
        pulse(1'b1, 1'b0, 1'b0);                 // edge 5: pause
        cycles(2);
        pulse(1'b1, 1'b1, 1'b0);                 // clear wins -> IDLE
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL clr_ss_running: got %b expected 0", sw_if.running); end
        cycles(15);
        checks++; if (disp() !== 24'h000000) begin errors++; $display("FAIL clr_ss_digits: got %h expected %h", disp(), 24'h000000); end
    endtask

    task automatic test_reset_in_lap();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);                 // edge 0
        cycles(14);
        pulse(1'b0, 1'b0, 1'b1);                 // edge 15: lap at 00:00.01
        cycles(10);
        checks++; if (sw_if.frozen !== 1'b1) begin errors++; $display("FAIL rl_pre_frozen: got %b expected 1", sw_if.frozen); end
        checks++; if (disp() !== 24'h000001) begin errors++; $display("FAIL rl_pre_digits: got %h expected %h", disp(), 24'h000001); end
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        checks++; if (disp() !== 24'h000000) begin errors++; $display("FAIL rl_digits: got %h expected %h", disp(), 24'h000000); end
        checks++; if ({sw_if.running, sw_if.frozen, sw_if.wrap} !== 3'b000) begin errors++; $display("FAIL rl_flags: got %b expected 000", {sw_if.running, sw_if.frozen, sw_if.wrap}); end
        cycles(20);
        checks++; if (disp() !== 24'h000000) begin errors++; $display("FAIL rl_stays_idle: got %h expected %h", disp(), 24'h000000); end
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        rst               = 1'b1;
        sw_if.start_stop  = 1'b0;
        sw_if.clear       = 1'b0;
        sw_if.lap         = 1'b0;
        sww_if.start_stop = 1'b0;
        sww_if.clear      = 1'b0;
        sww_if.lap        = 1'b0;
        @(negedge clk);
        test_reset();
        test_start();
        test_pause();
        test_clear();
        test_lap();
        test_idle_ignores();
        test_wrap();
        test_clear_start_same();
        test_reset_in_lap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
